// File: rtl/qspi_fast_read.sv
// Fast Read Quad I/O (EBh) engine for the 25Q32: one 24-bit word-read request
// becomes one flash transaction, returning 4 bytes as a little-endian word.
module qspi_fast_read #(
    parameter int          ADDR_W      = 24,
    parameter int          DATA_W      = 32,
    parameter logic [7:0]  MODE_BYTE   = 8'hFF,
    parameter int          CS_HIGH_MIN = 2
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              cs_n,
    output logic              sck,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe,
    input  logic [3:0]        io_in
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_DUMMY = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd6;

    localparam logic [7:0] CMD_FAST_READ_QUAD = 8'hEB;

    logic [2:0]        state;
    logic [3:0]        cnt;
    logic              half;
    logic [7:0]        cmd_sh;
    logic [ADDR_W+7:0] addr_sh;

    assign req_ready = (state == S_IDLE) && init_done && !ARESET;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= S_IDLE;
            cnt       <= '0;
            half      <= 1'b0;
            cmd_sh    <= '0;
            addr_sh   <= '0;
            cs_n      <= 1'b1;
            sck       <= 1'b0;
            io_out    <= '0;
            io_oe     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        state   <= S_CMD;
                        cnt     <= '0;
                        half    <= 1'b0;
                        cs_n    <= 1'b0;
                        sck     <= 1'b0;
                        io_oe   <= 4'b1101;
                        io_out  <= {2'b11, 1'b0, CMD_FAST_READ_QUAD[7]};
                        cmd_sh  <= {CMD_FAST_READ_QUAD[6:0], 1'b0};
                        // Word-aligned on the wire regardless of the low address bits.
                        addr_sh <= {req_addr[ADDR_W-1:2], req_addr[1:0] & 2'b00, MODE_BYTE};
                    end
                end

                S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                    // One extra sck-low cycle after the last data nibble before CS rises.
                    if (state == S_DATA && cnt[3]) begin
                        state     <= S_RESP;
                        cnt       <= '0;
                        cs_n      <= 1'b1;
                        rsp_valid <= 1'b1;
                    end else if (!half) begin
                        sck  <= 1'b1;
                        half <= 1'b1;
                    end else begin
                        sck  <= 1'b0;
                        half <= 1'b0;
                        case (state)
                            S_CMD: begin
                                if (cnt == 4'd7) begin
                                    state  <= S_ADDR;
                                    cnt    <= '0;
                                    io_oe  <= 4'hF;
                                    io_out <= addr_sh[ADDR_W+7 -: 4];
                                end else begin
                                    cnt    <= cnt + 4'd1;
                                    io_out <= {2'b11, 1'b0, cmd_sh[7]};
                                    cmd_sh <= {cmd_sh[6:0], 1'b0};
                                end
                            end
                            S_ADDR: begin
                                addr_sh <= {addr_sh[ADDR_W+3:0], 4'h0};
                                if (cnt == 4'd7) begin
                                    state  <= S_DUMMY;
                                    cnt    <= '0;
                                    io_oe  <= '0;
                                    io_out <= '0;
                                end else begin
                                    cnt    <= cnt + 4'd1;
                                    io_out <= addr_sh[ADDR_W+3 -: 4];
                                end
                            end
                            S_DUMMY: begin
                                if (cnt == 4'd3) begin
                                    state <= S_DATA;
                                    cnt   <= '0;
                                end else begin
                                    cnt <= cnt + 4'd1;
                                end
                            end
                            default: begin
                                // Nibble k lands in byte k/2, high nibble first.
                                rsp_data[{cnt[2:1], ~cnt[0], 2'b00} +: 4] <= io_in;
                                cnt <= cnt + 4'd1;
                            end
                        endcase
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_GAP;
                        cnt       <= '0;
                    end
                end

                S_GAP: begin
                    if (cnt == 4'(CS_HIGH_MIN - 1)) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_fast_read.sv
// Directed bench for qspi_fast_read with a behavioural quad-SPI flash model.
module tb_qspi_fast_read;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        init_done;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        cs_n;
    logic        sck;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic [3:0]  io_in = 4'h0;

    int tests_run = 0;
    int tests_failed = 0;

    qspi_fast_read #(
        .ADDR_W(24),
        .DATA_W(32),
        .MODE_BYTE(8'hFF),
        .CS_HIGH_MIN(2)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .init_done(init_done),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .cs_n(cs_n),
        .sck(sck),
        .io_out(io_out),
        .io_oe(io_oe),
        .io_in(io_in)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Flash contents: 11 22 33 44 at 0x100..0x103, otherwise addr ^ 5A.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (a >= 24'h000100 && a <= 24'h000103)
            return 8'h11 * ({6'd0, a[1:0]} + 8'd1);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [3:0] nib(input logic [23:0] a, input int k);
        logic [7:0] b;
        b = flash_byte(a + 24'(k / 2));
        return (k % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    // Flash model: captures on sck rise, presents data from the rise of each data period.
    int          rise = 0;
    logic [7:0]  cmd_cap = '0;
    logic [31:0] adr_cap = '0;
    logic [3:0]  oe_cmd = '0, oe_adr = '0, oe_dum = '0;

    always @(posedge sck or posedge cs_n) begin
        if (cs_n) begin
            rise  = 0;
            io_in = 4'h0;
        end else begin
            rise++;
            if (rise <= 8) begin
                cmd_cap = {cmd_cap[6:0], io_out[0]};
                if (rise == 1) oe_cmd = io_oe;
            end else if (rise <= 16) begin
                adr_cap = {adr_cap[27:0], io_out};
                if (rise == 9) oe_adr = io_oe;
            end else if (rise <= 20) begin
                if (rise == 17) oe_dum = io_oe;
            end else if (rise <= 28) begin
                io_in = nib(adr_cap[31:8], rise - 21);
            end
        end
    end

    int hi_run = 0;
    int last_hi = 0;
    always @(posedge ACLK) begin
        if (cs_n === 1'b1) hi_run <= hi_run + 1;
        else begin
            if (hi_run != 0) last_hi <= hi_run;
            hi_run <= 0;
        end
    end

    task automatic wait_accept(input logic [23:0] addr);
        int n;
        @(negedge ACLK);
        req_valid = 1'b1;
        req_addr  = addr;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        check("accept_timeout", 32'(n < 100), 32'd1);
        @(posedge ACLK);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [23:0] addr, input int hold, input logic [31:0] exp);
        int  k;
        int  gap;
        logic stable_bad;
        rsp_ready = (hold == 0);
        wait_accept(addr);
        check("t0_cs_n", 32'(cs_n), 32'd0);
        check("t0_sck", 32'(sck), 32'd0);
        check("t0_io0", 32'(io_out[0]), 32'd1);
        check("t0_oe", 32'(io_oe), 32'hD);
        @(posedge ACLK); #1;
        check("t1_sck", 32'(sck), 32'd1);
        k = 1;
        while (!rsp_valid && k < 100) begin
            @(posedge ACLK); #1;
            k++;
        end
        check("latency", k, 57);
        check("resp_cs_n", 32'(cs_n), 32'd1);
        check("rsp_data", rsp_data, exp);
        check("cmd_bits", 32'(cmd_cap), 32'hEB);
        check("addr_mode", adr_cap, {addr[23:2], 2'b00, 8'hFF});
        check("oe_addr", 32'(oe_adr), 32'hF);
        check("oe_dummy", 32'(oe_dum), 32'h0);
        check("cmd_oe_at_rise", 32'(oe_cmd), 32'hD);
        check("cs_high_gap", 32'(last_hi >= 2), 32'd1);
        if (hold > 0) begin
            stable_bad = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(posedge ACLK); #1;
                if (rsp_valid !== 1'b1 || rsp_data !== exp || cs_n !== 1'b1 || req_ready !== 1'b0)
                    stable_bad = 1'b1;
            end
            check("hold_stable", 32'(stable_bad), 32'd0);
            @(negedge ACLK);
            rsp_ready = 1'b1;
        end
        @(posedge ACLK); #1;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        gap = 0;
        while (!req_ready && gap < 10) begin
            @(posedge ACLK); #1;
            gap++;
        end
        check("ready_gap", gap, 2);
    endtask

    initial begin
        logic bad_a, bad_b;
        ARESET    = 1'b1;
        init_done = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_data", rsp_data, 32'd0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        check("idle_cs_n", 32'(cs_n), 32'd1);
        check("idle_sck", 32'(sck), 32'd0);
        check("idle_oe", 32'(io_oe), 32'd0);
        check("idle_valid", 32'(rsp_valid), 32'd0);
        check("idle_ready", 32'(req_ready), 32'd1);

        // Requests refused while init_done is low
        init_done = 1'b0;
        req_valid = 1'b1;
        req_addr  = 24'h000100;
        bad_a = 1'b0; bad_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge ACLK); #1;
            if (req_ready !== 1'b0) bad_a = 1'b1;
            if (cs_n !== 1'b1) bad_b = 1'b1;
        end
        check("refused_ready", 32'(bad_a), 32'd0);
        check("refused_cs", 32'(bad_b), 32'd0);
        req_valid = 1'b0;
        init_done = 1'b1;
        @(posedge ACLK); #1;

        do_read(24'h000100, 0, 32'h44332211);
        do_read(24'h000100, 10, 32'h44332211);
        do_read(24'h000000, 0, 32'h59585B5A);
        do_read(24'h000004, 0, 32'h5D5C5F5E);

        // Reset in the middle of a transaction
        rsp_ready = 1'b1;
        wait_accept(24'h000100);
        repeat (30) @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        check("abort_cs_n", 32'(cs_n), 32'd1);
        check("abort_sck", 32'(sck), 32'd0);
        check("abort_oe", 32'(io_oe), 32'd0);
        check("abort_valid", 32'(rsp_valid), 32'd0);
        ARESET = 1'b0;
        bad_a = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge ACLK); #1;
            if (rsp_valid !== 1'b0) bad_a = 1'b1;
        end
        check("abort_no_rsp", 32'(bad_a), 32'd0);
        do_read(24'h000100, 0, 32'h44332211);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
